simple_spi_m_bit_rw: RTL and testbench
======================================

// Module: simple_spi_m_bit_rw
// PURPOSE
//  - Single-channel SPI master in mode 0 (CPOL=0, CPHA=0), MSB first.
//  - Full-duplex transfer of 1..reg_width bits; the length is chosen per transfer.
//  - Shifts d_in out on mosi while shifting miso into d_out.
//  - Sits between a local register interface and one external SPI slave.
// PARAMETERS
//  - reg_width  8  width of the d_in/d_out data words and the maximum transfer length.
// PORTS
//  - sys_clk  in   1                        system clock; all logic on its rising edge.
//  - rstn     in   1                        reset, asynchronous, active-low.
//  - t_start  in   1                        transfer request; rising edge starts a transfer.
//  - d_in     in   reg_width                transmit word; its low t_size bits are sent.
//  - t_size   in   $clog2(reg_width)+1      number of bits to transfer.
//  - d_out    out  reg_width                received word, right-aligned, upper bits zero.
//  - cs       out  1                        chip select, active-low.
//  - spi_clk  out  1                        SPI clock = sys_clk/2 during a transfer; idles low.
//  - mosi     out  1                        serial data out.
//  - miso     in   1                        serial data in.
// BEHAVIOUR
//  - Clock and reset: one clock (sys_clk); reset is asynchronous and active-low (rstn).
//  - Reset values (apply immediately, also mid-transfer; the transfer is aborted):
//    cs=1, spi_clk=0, mosi=0, d_out=0, state=IDLE, t_start edge register=0.
//  - Start detection:
//    - t_start is registered each cycle; start = t_start & ~t_start_q, evaluated only in IDLE.
//    - A start edge arriving while busy is ignored; holding t_start high never retriggers.
//  - Length: n = t_size. If t_size==0 or t_size>reg_width, use n = reg_width.
//  - States: IDLE -> SHIFT -> TRAIL -> IDLE.
//  - IDLE, start seen:
//    - Latch tx = d_in << (reg_width-n); clear rx; cnt = n; phase = 0.
//    - Drive cs<=0 and mosi<=tx MSB; go to SHIFT. spi_clk stays 0, giving a half-period setup.
//  - SHIFT, phase 0: spi_clk<=1; rx <= {rx[reg_width-2:0], miso}; phase<=1.
//  - SHIFT, phase 1: spi_clk<=0; cnt<=cnt-1; phase<=0.
//    - If cnt==1, go to TRAIL.
//    - Otherwise tx<<=1 and mosi<=next bit.
//  - TRAIL (one cycle): cs<=1; mosi<=0; d_out<=rx; go to IDLE.
//  - Timing for n bits: 2n+2 sys_clk cycles from the start-edge sample to IDLE.
//    - cs is low for 2n+1 cycles; spi_clk produces exactly n rising edges.
//  - Bit timing:
//    - mosi changes only while spi_clk is low (on or after its falling edge).
//    - miso is sampled on the sys_clk edge that raises spi_clk.
//  - d_out holds its value between transfers and updates only in TRAIL.
//  - d_in and t_size may change freely after the start cycle.
// STRUCTURE
//  - Package simple_spi_pkg: typedef enum logic [1:0] {IDLE, SHIFT, TRAIL} spi_state_t.
//    - Also holds the helper function that clamps t_size to 1..reg_width.
//  - Single flat module; no sub-module required.
//  - tx and rx shift registers, cnt sized $clog2(reg_width)+1, and a 1-bit phase
//    register live inline.
// TESTING
//  - Reset: rstn=0 -> cs=1, spi_clk=0, mosi=0, d_out=0.
//    - Assert rstn mid-transfer -> the same values appear immediately.
//  - Loopback (miso=mosi), d_in=8'hAA, t_size=8, one t_start pulse:
//    - mosi sequence 1,0,1,0,1,0,1,0 at the spi_clk rising edges.
//    - 8 spi_clk pulses; cs low for 17 cycles; d_out=8'hAA afterwards.
//  - miso tied to 1, d_in=8'h00, t_size=4 -> 4 spi_clk pulses; d_out=8'h0F.
//  - t_size=0 with d_in=8'h5A in loopback -> full 8-bit transfer; d_out=8'h5A.
//  - t_start held high across and after a transfer -> exactly one transfer.
//    - A second pulse during the transfer is ignored.
//  - Back-to-back transfers: 8'h3C then 8'hC3 in loopback -> d_out=8'h3C, then 8'hC3.
//    - cs returns high for at least one cycle between the two transfers.

Source files
------------

// File: rtl/simple_spi_pkg.sv
// rtl/simple_spi_pkg.sv - shared types and helpers for the mode-0 SPI master
package simple_spi_pkg;

    // Transfer sequencer states: wait for a request, shift bits, release chip select.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        TRAIL = 2'd2
    } spi_state_t;

    // Map a requested length onto 1..width; zero or oversize requests mean a full word.
    function automatic int unsigned clamp_len(input int unsigned size, input int unsigned width);
        if ((size == 0) || (size > width)) begin
            return width;
        end
        return size;
    endfunction

endpackage

// File: rtl/simple_spi_m_bit_rw.sv
// rtl/simple_spi_m_bit_rw.sv - SPI mode-0 master, MSB first, 1..reg_width bit full-duplex transfers
module simple_spi_m_bit_rw
    import simple_spi_pkg::*;
#(
    parameter int unsigned reg_width = 8
) (
    input  logic                         sys_clk,
    input  logic                         rstn,
    input  logic                         t_start,
    input  logic [reg_width-1:0]         d_in,
    input  logic [$clog2(reg_width):0]   t_size,
    output logic [reg_width-1:0]         d_out,
    output logic                         cs,
    output logic                         spi_clk,
    output logic                         mosi,
    input  logic                         miso
);

    localparam int unsigned CW = $clog2(reg_width) + 1;

    spi_state_t             state_q;
    logic                   t_start_q;
    logic [reg_width-1:0]   tx_q;
    logic [reg_width-1:0]   rx_q;
    logic [CW-1:0]          cnt_q;
    logic                   phase_q;
    logic                   cs_q;
    logic                   spi_clk_q;
    logic                   mosi_q;
    logic [reg_width-1:0]   d_out_q;

    logic                   start_d;
    logic [CW-1:0]          n_len_d;
    logic [reg_width-1:0]   tx_load_d;

    // Edge detect on the request and left-justify the transmit word so its MSB leads.
    always_comb begin
        start_d   = t_start & ~t_start_q;
        n_len_d   = CW'(clamp_len(32'(t_size), reg_width));
        tx_load_d = d_in << (reg_width - 32'(n_len_d));
    end

    // Transfer sequencer: every spi_clk half-period is one sys_clk cycle, outputs registered.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            t_start_q <= 1'b0;
            tx_q      <= '0;
            rx_q      <= '0;
            cnt_q     <= '0;
            phase_q   <= 1'b0;
            cs_q      <= 1'b1;
            spi_clk_q <= 1'b0;
            mosi_q    <= 1'b0;
            d_out_q   <= '0;
        end else begin
            t_start_q <= t_start;
            case (state_q)
                IDLE: begin
                    if (start_d) begin
                        tx_q    <= tx_load_d;
                        rx_q    <= '0;
                        cnt_q   <= n_len_d;
                        phase_q <= 1'b0;
                        cs_q    <= 1'b0;
                        // First bit goes out with cs; spi_clk stays low for a half-period of setup.
                        mosi_q  <= tx_load_d[reg_width-1];
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!phase_q) begin
                        // Rising spi_clk edge: the slave sees mosi, we capture miso.
                        spi_clk_q <= 1'b1;
                        rx_q      <= {rx_q[reg_width-2:0], miso};
                        phase_q   <= 1'b1;
                    end else begin
                        // Falling spi_clk edge: advance to the next bit or finish.
                        spi_clk_q <= 1'b0;
                        cnt_q     <= cnt_q - CW'(1);
                        phase_q   <= 1'b0;
                        if (cnt_q == CW'(1)) begin
                            state_q <= TRAIL;
                        end else begin
                            tx_q   <= tx_q << 1;
                            mosi_q <= tx_q[reg_width-2];
                        end
                    end
                end
                TRAIL: begin
                    cs_q    <= 1'b1;
                    mosi_q  <= 1'b0;
                    d_out_q <= rx_q;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign d_out   = d_out_q;
    assign cs      = cs_q;
    assign spi_clk = spi_clk_q;
    assign mosi    = mosi_q;

endmodule

// File: tb/tb_simple_spi_m_bit_rw.sv
// tb/tb_simple_spi_m_bit_rw.sv - directed bench for the SPI master
module tb_simple_spi_m_bit_rw;

    logic       sys_clk;
    logic       rstn;
    logic       t_start;
    logic [7:0] d_in;
    logic [3:0] t_size;
    logic [7:0] d_out;
    logic       cs;
    logic       spi_clk;
    logic       mosi;
    logic       miso;
    logic       loop_en;
    logic       miso_fix;

    int checks;
    int errors;
    int pulse_cnt;
    int cs_low_cnt;
    int cs_falls;
    logic [7:0] mosi_seq;

    simple_spi_m_bit_rw #(.reg_width(8)) dut (
        .sys_clk (sys_clk),
        .rstn    (rstn),
        .t_start (t_start),
        .d_in    (d_in),
        .t_size  (t_size),
        .d_out   (d_out),
        .cs      (cs),
        .spi_clk (spi_clk),
        .mosi    (mosi),
        .miso    (miso)
    );

    assign miso = loop_en ? mosi : miso_fix;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge spi_clk) begin
        pulse_cnt = pulse_cnt + 1;
        mosi_seq  = {mosi_seq[6:0], mosi};
    end

    always @(negedge sys_clk) begin
        if (rstn && (cs === 1'b0)) cs_low_cnt = cs_low_cnt + 1;
    end

    always @(negedge cs) begin
        if (rstn) cs_falls = cs_falls + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        pulse_cnt  = 0;
        cs_low_cnt = 0;
        cs_falls   = 0;
        mosi_seq   = 8'h00;
    endtask

    task automatic start_pulse(input logic [7:0] d, input logic [3:0] sz);
        @(negedge sys_clk);
        d_in    = d;
        t_size  = sz;
        t_start = 1'b1;
        @(negedge sys_clk);
        t_start = 1'b0;
    endtask

    // Wait for cs to drop (if not already) and return high, with a cycle budget.
    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while ((cs !== 1'b0) && (k < 10)) begin
            @(negedge sys_clk);
            k++;
        end
        while ((cs !== 1'b1) && (k < 100)) begin
            @(negedge sys_clk);
            k++;
        end
        chk(tag, {31'd0, (k < 100) && (cs === 1'b1)}, 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge sys_clk);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rstn     = 1'b0;
        t_start  = 1'b0;
        d_in     = 8'h00;
        t_size   = 4'd0;
        loop_en  = 1'b1;
        miso_fix = 1'b0;
        clear_mon();

        // Reset values
        idle_cycles(3);
        chk("rst_cs", {31'd0, cs}, 32'd1);
        chk("rst_sclk", {31'd0, spi_clk}, 32'd0);
        chk("rst_mosi", {31'd0, mosi}, 32'd0);
        chk("rst_dout", {24'd0, d_out}, 32'h00);
        rstn = 1'b1;
        idle_cycles(2);

        // Loopback AA, 8 bits
        clear_mon();
        start_pulse(8'hAA, 4'd8);
        wait_done("aa_done");
        chk("aa_pulses", pulse_cnt, 32'd8);
        chk("aa_mosi_seq", {24'd0, mosi_seq}, 32'hAA);
        chk("aa_cs_low", cs_low_cnt, 32'd17);
        chk("aa_dout", {24'd0, d_out}, 32'hAA);
        idle_cycles(3);

        // miso tied high, 4 bits of zeros out
        loop_en  = 1'b0;
        miso_fix = 1'b1;
        clear_mon();
        start_pulse(8'h00, 4'd4);
        wait_done("m1_done");
        chk("m1_pulses", pulse_cnt, 32'd4);
        chk("m1_cs_low", cs_low_cnt, 32'd9);
        chk("m1_mosi_seq", {28'd0, mosi_seq[3:0]}, 32'h0);
        chk("m1_dout", {24'd0, d_out}, 32'h0F);
        idle_cycles(3);

        // t_size=0 means a full word
        loop_en = 1'b1;
        clear_mon();
        start_pulse(8'h5A, 4'd0);
        wait_done("z_done");
        chk("z_pulses", pulse_cnt, 32'd8);
        chk("z_dout", {24'd0, d_out}, 32'h5A);
        idle_cycles(3);

        // d_out holds between transfers
        idle_cycles(5);
        chk("hold_dout", {24'd0, d_out}, 32'h5A);

        // t_start held high: exactly one transfer
        clear_mon();
        @(negedge sys_clk);
        d_in    = 8'h81;
        t_size  = 4'd8;
        t_start = 1'b1;
        @(negedge sys_clk);
        d_in    = 8'h00;
        wait_done("held_done");
        idle_cycles(20);
        t_start = 1'b0;
        chk("held_falls", cs_falls, 32'd1);
        chk("held_dout", {24'd0, d_out}, 32'h81);
        idle_cycles(3);

        // Second pulse while busy is ignored
        clear_mon();
        start_pulse(8'h96, 4'd8);
        idle_cycles(4);
        t_start = 1'b1;
        d_in    = 8'h11;
        @(negedge sys_clk);
        t_start = 1'b0;
        wait_done("busy_done");
        idle_cycles(10);
        chk("busy_falls", cs_falls, 32'd1);
        chk("busy_dout", {24'd0, d_out}, 32'h96);

        // Back-to-back transfers
        clear_mon();
        start_pulse(8'h3C, 4'd8);
        wait_done("b2b1_done");
        chk("b2b1_dout", {24'd0, d_out}, 32'h3C);
        start_pulse(8'hC3, 4'd8);
        wait_done("b2b2_done");
        chk("b2b2_dout", {24'd0, d_out}, 32'hC3);
        chk("b2b_falls", cs_falls, 32'd2);
        chk("b2b_cs_low", cs_low_cnt, 32'd34);
        idle_cycles(3);

        // Asynchronous reset mid-transfer
        start_pulse(8'hFF, 4'd8);
        idle_cycles(3);
        #2;
        chk("mid_cs_busy", {31'd0, cs}, 32'd0);
        rstn = 1'b0;
        #1;
        chk("mid_cs", {31'd0, cs}, 32'd1);
        chk("mid_sclk", {31'd0, spi_clk}, 32'd0);
        chk("mid_mosi", {31'd0, mosi}, 32'd0);
        chk("mid_dout", {24'd0, d_out}, 32'h00);
        idle_cycles(2);
        rstn = 1'b1;
        idle_cycles(2);

        // Transfer works again after reset, 3 bits
        clear_mon();
        start_pulse(8'h05, 4'd3);
        wait_done("post_done");
        chk("post_pulses", pulse_cnt, 32'd3);
        chk("post_dout", {24'd0, d_out}, 32'h05);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
